// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared state type and width helpers for the FIR MAC engine
package fir_pkg;

  localparam int MAX_TAPS = 16;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_state_t;

  // Headroom of clog2(ntaps) bits lets every tap add a full-scale product without overflow.
  function automatic int acc_width(input int ntaps, input int dw);
    return 2 * dw + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_acc_narrow.sv
// rtl/fir_acc_narrow.sv - accumulator shift and narrow to sample width
// FIR_SAT_EN defined: saturate to the signed DW range; undefined: keep low DW bits.
module fir_acc_narrow #(
  parameter int ACC_W     = 67,
  parameter int DW        = 32,
  parameter int OUT_SHIFT = 15
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [DW-1:0]    o_sample
);

  logic signed [ACC_W-1:0] w_shifted;

  assign w_shifted = i_acc >>> OUT_SHIFT;

`ifdef FIR_SAT_EN
  logic [ACC_W-DW:0] w_upper;
  logic              w_fits;

  // The value fits when every bit above the result's sign bit repeats that sign bit.
  assign w_upper = w_shifted[ACC_W-1:DW-1];
  assign w_fits  = (&w_upper) | ~(|w_upper);

  always_comb begin
    if (w_fits) begin
      o_sample = w_shifted[DW-1:0];
    end else if (w_shifted[ACC_W-1]) begin
      o_sample = {1'b1, {(DW-1){1'b0}}};
    end else begin
      o_sample = {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  logic w_unused_hi;

  assign w_unused_hi = ^w_shifted[ACC_W-1:DW];
  assign o_sample    = w_shifted[DW-1:0];
`endif

endmodule

// File: rtl/fir_mac_core.sv
// rtl/fir_mac_core.sv - sequential FIR engine, one tap per clock on a shared multiplier
// Output narrowing mode selected by FIR_SAT_EN (see fir_acc_narrow).
module fir_mac_core
  import fir_pkg::*;
#(
  parameter int NTAPS     = 8,
  parameter int DW        = 32,
  parameter int OUT_SHIFT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [DW-1:0] sample_in,
  input  logic                 coeff_wr_en,
  input  logic [3:0]           coeff_wr_addr,
  input  logic signed [DW-1:0] coeff_wr_data,
  output logic signed [DW-1:0] sample_out,
  output logic                 done,
  output logic                 busy
);

  localparam int ACC_W = acc_width(NTAPS, DW);
  localparam int IDX_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  fir_state_t              r_state;
  fir_state_t              w_next_state;
  logic                    r_start_q;
  logic signed [DW-1:0]    r_x [NTAPS];
  logic signed [DW-1:0]    r_h [NTAPS];
  logic signed [ACC_W-1:0] r_acc;
  logic [IDX_W-1:0]        r_idx;
  logic signed [DW-1:0]    r_sample_out;
  logic                    r_done;
  logic                    r_busy;

  logic                    w_trig;
  logic                    w_last;
  logic                    w_coeff_ok;
  logic signed [2*DW-1:0]  w_prod;
  logic signed [DW-1:0]    w_narrow;

  assign w_trig     = start & ~r_start_q;
  assign w_last     = (r_idx == IDX_W'(NTAPS - 1));
  assign w_coeff_ok = coeff_wr_en && (32'(coeff_wr_addr) < 32'(NTAPS));
  assign w_prod     = r_x[r_idx] * r_h[r_idx];

  assign sample_out = r_sample_out;
  assign done       = r_done;
  assign busy       = r_busy;

  fir_acc_narrow #(
    .ACC_W    (ACC_W),
    .DW       (DW),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_narrow (
    .i_acc   (r_acc),
    .o_sample(w_narrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_trig) w_next_state = MAC;
      MAC:     if (w_last) w_next_state = OUT;
      OUT:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q    <= 1'b0;
      r_acc        <= '0;
      r_idx        <= '0;
      r_sample_out <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      for (int i = 0; i < NTAPS; i++) r_x[i] <= '0;
    end else begin
      r_start_q <= start;
      case (r_state)
        IDLE: begin
          if (w_trig) begin
            for (int i = NTAPS - 1; i > 0; i--) r_x[i] <= r_x[i-1];
            r_x[0] <= sample_in;
            r_acc  <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
            r_busy <= 1'b1;
          end
        end
        MAC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        OUT: begin
          r_sample_out <= w_narrow;
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // A write landing during MAC is seen only by taps the sweep has not reached yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) r_h[i] <= '0;
    end else if (w_coeff_ok) begin
      r_h[coeff_wr_addr[IDX_W-1:0]] <= coeff_wr_data;
    end
  end

endmodule
